// File: rtl/mux_chan_sel_if.sv
`default_nettype none
// ============================================================================
//  Module   : mux_chan_sel_if
//  Purpose  : Bundles the channel-side and consumer-side handshake of the
//             N:1 registered channel multiplexer.
//  Modports : slave  - the multiplexer itself (samples channels, drives output)
//             master - the surrounding producers/consumer (drives channels,
//                      select and out_ready)
//  Signals  : in_data   N_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
//             in_valid  N_CH         per-channel valid
//             in_ready  N_CH         per-channel ready, at most one bit set
//             sel       SEL_W        requested channel
//             sel_load  1            load sel into the select register
//             sel_err   1            one-cycle pulse on out-of-range load
//             out_data  DATA_W       registered selected data
//             out_ch    SEL_W        channel out_data came from
//             out_valid 1            out_data/out_ch valid
//             out_ready 1            consumer accepts on out_valid & out_ready
//  Revision : 1.0 - initial release
// ============================================================================
interface mux_chan_sel_if #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 8
);
  localparam int SEL_W = $clog2(N_CH);

  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        in_valid;
  logic [N_CH-1:0]        in_ready;
  logic [SEL_W-1:0]       sel;
  logic                   sel_load;
  logic                   sel_err;
  logic [DATA_W-1:0]      out_data;
  logic [SEL_W-1:0]       out_ch;
  logic                   out_valid;
  logic                   out_ready;

  modport slave (
    input  in_data, in_valid, sel, sel_load, out_ready,
    output in_ready, sel_err, out_data, out_ch, out_valid
  );

  modport master (
    output in_data, in_valid, sel, sel_load, out_ready,
    input  in_ready, sel_err, out_data, out_ch, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/mux_chan_sel.sv
`default_nettype none
// ============================================================================
//  Module   : mux_chan_sel
//  Purpose  : Registered N_CH:1 channel multiplexer with valid/ready flow
//             control, a held select register, a one-deep output register
//             and range checking of select loads.
//  Ports    : clk  - rising-edge clock
//             rst  - synchronous active-high reset
//             bus  - mux_chan_sel_if.slave (channel inputs, select, output)
//  Config   : MUX_SCAN_EN - when defined, the select register advances
//             round-robin after every accepted word (a sel_load in the same
//             cycle takes priority over the advance).
//  Revision : 1.0 - initial release
// ============================================================================
module mux_chan_sel #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  mux_chan_sel_if.slave      bus
);
  localparam int SEL_W = $clog2(N_CH);

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    cur_sel_q, cur_sel_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_ch_q, out_ch_d;
  logic                sel_err_q, sel_err_d;

  logic                can_take;
  logic                accept;
  logic                sel_oor;
  logic [DATA_W-1:0]   sel_data;
  logic [N_CH-1:0]     in_ready;

  // A select value can only exceed the channel range when N_CH is not a
  // power of two; otherwise every encodable value is a real channel.
  if ((1 << SEL_W) == N_CH) begin : g_sel_pow2
    assign sel_oor = 1'b0;
  end else begin : g_sel_npow2
    assign sel_oor = (bus.sel >= SEL_W'(N_CH));
  end

  // The output register can take a word when empty or when it is being
  // popped in this same cycle (full throughput).
  assign can_take = (state_q == OUT_EMPTY) | bus.out_ready;
  assign sel_data = bus.in_data[cur_sel_q*DATA_W +: DATA_W];
  assign accept   = bus.in_valid[cur_sel_q] & can_take & ~rst;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = can_take & ~rst & (cur_sel_q == SEL_W'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    cur_sel_d  = cur_sel_q;
    sel_err_d  = bus.sel_load & sel_oor;

    if (accept) begin
      // Uses the select value held before any load in this cycle.
      out_data_d = sel_data;
      out_ch_d   = cur_sel_q;
      state_d    = OUT_FULL;
    end else if ((state_q == OUT_FULL) && bus.out_ready) begin
      state_d    = OUT_EMPTY;
    end

`ifdef MUX_SCAN_EN
    if (accept) begin
      cur_sel_d = (cur_sel_q == SEL_W'(N_CH - 1)) ? '0 : cur_sel_q + SEL_W'(1);
    end
`endif

    // An explicit load overrides any round-robin advance.
    if (bus.sel_load && !sel_oor) begin
      cur_sel_d = bus.sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= OUT_EMPTY;
      cur_sel_q  <= '0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_sel_q  <= cur_sel_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == OUT_FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.sel_err   = sel_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_chan_sel.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_chan_sel
//  Purpose  : Directed self-checking bench for mux_chan_sel. Drives an 8- and
//             a 5-channel instance from one linear sequence of steps and
//             compares outputs against hand-computed values.
//  Config   : MUX_SCAN_EN - selects the expected round-robin sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_chan_sel;
  logic clk;
  logic rst;

  int n_cmp;
  int n_err;

`ifdef MUX_SCAN_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  mux_chan_sel_if #(.N_CH(8), .DATA_W(8)) b8 ();
  mux_chan_sel_if #(.N_CH(5), .DATA_W(8)) b5 ();

  mux_chan_sel #(.N_CH(8), .DATA_W(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
  mux_chan_sel #(.N_CH(5), .DATA_W(8)) u5 (.clk(clk), .rst(rst), .bus(b5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then let registered outputs settle.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    b8.in_data = '0; b8.in_valid = '0; b8.sel = '0; b8.sel_load = 1'b0; b8.out_ready = 1'b0;
    b5.in_data = '0; b5.in_valid = '0; b5.sel = '0; b5.sel_load = 1'b0; b5.out_ready = 1'b0;

    // ---- reset ----
    step();
    step();
    #1 check("rst_in_ready_zero", 32'(b8.in_ready), 32'h00);
    rst = 1'b0;
    #1 check("rst_out_valid", 32'(b8.out_valid), 32'h0);
    check("rst_out_data", 32'(b8.out_data), 32'h00);
    check("rst_out_ch", 32'(b8.out_ch), 32'h0);
    check("rst_sel_err", 32'(b8.sel_err), 32'h0);
    check("rst_in_ready_ch0", 32'(b8.in_ready), 32'h01);

    // ---- basic select and transfer on channel 3 ----
    b8.out_ready = 1'b1;
    b8.sel = 3'd3; b8.sel_load = 1'b1;
    step();
    b8.sel_load = 1'b0;
    #1 check("sel3_in_ready", 32'(b8.in_ready), 32'h08);
    b8.in_data[3*8 +: 8] = 8'hA5; b8.in_valid = 8'h08;
    step();
    check("xfer_out_valid", 32'(b8.out_valid), 32'h1);
    check("xfer_out_data", 32'(b8.out_data), 32'hA5);
    check("xfer_out_ch", 32'(b8.out_ch), 32'h3);
    b8.in_valid = 8'h00;
    step();
    check("pop_empty", 32'(b8.out_valid), 32'h0);

    // ---- backpressure ----
    b8.out_ready = 1'b0;
    b8.in_data[3*8 +: 8] = 8'h10; b8.in_valid = 8'h08;
    step();
    check("bp_capture", 32'(b8.out_data), 32'h10);
    #1 check("bp_in_ready_zero", 32'(b8.in_ready), 32'h00);
    b8.in_data[3*8 +: 8] = 8'h11;
    step();
    check("bp_hold1", 32'(b8.out_data), 32'h10);
    step();
    check("bp_hold2", 32'(b8.out_data), 32'h10);
    check("bp_hold_valid", 32'(b8.out_valid), 32'h1);
    b8.out_ready = 1'b1;
    #1 check("bp_release_ready", 32'(b8.in_ready), 32'h08);
    step();
    check("bp_word2", 32'(b8.out_data), 32'h11);
    b8.in_data[3*8 +: 8] = 8'h12;
    step();
    check("bp_word3", 32'(b8.out_data), 32'h12);
    check("bp_word3_valid", 32'(b8.out_valid), 32'h1);
    b8.in_valid = 8'h00;
    step();
    check("bp_drained", 32'(b8.out_valid), 32'h0);

    // ---- same-cycle sel_load and accept: old select wins for this word ----
    b8.in_data[3*8 +: 8] = 8'h33; b8.in_data[2*8 +: 8] = 8'h22;
    b8.in_valid = 8'h0C;
    b8.sel = 3'd2; b8.sel_load = 1'b1;
    step();
    b8.sel_load = 1'b0;
    check("ld_acc_out_ch", 32'(b8.out_ch), 32'h3);
    check("ld_acc_out_data", 32'(b8.out_data), 32'h33);
    step();
    check("ld_next_out_ch", 32'(b8.out_ch), 32'h2);
    check("ld_next_out_data", 32'(b8.out_data), 32'h22);

    // ---- reset while full and stalled ----
    b8.out_ready = 1'b0;
    b8.in_valid  = 8'h04;
    step();
    check("prerst_full", 32'(b8.out_valid), 32'h1);
    rst = 1'b1;
    #1 check("rst_hold_in_ready", 32'(b8.in_ready), 32'h00);
    step();
    rst = 1'b0;
    b8.in_valid = 8'h00;
    b8.out_ready = 1'b1;
    check("midrst_out_valid", 32'(b8.out_valid), 32'h0);
    check("midrst_out_data", 32'(b8.out_data), 32'h00);
    check("midrst_out_ch", 32'(b8.out_ch), 32'h0);
    #1 check("midrst_cur_sel0", 32'(b8.in_ready), 32'h01);

    // ---- out-of-range select on the 5-channel instance ----
    b5.out_ready = 1'b1;
    b5.sel = 3'd1; b5.sel_load = 1'b1;
    step();
    check("n5_sel1_no_err", 32'(b5.sel_err), 32'h0);
    b5.sel = 3'd6;
    step();
    b5.sel_load = 1'b0;
    check("n5_sel6_err", 32'(b5.sel_err), 32'h1);
    #1 check("n5_sel_kept", 32'(b5.in_ready), 32'h02);
    b5.in_data[1*8 +: 8] = 8'h5A; b5.in_valid = 5'b00010;
    step();
    check("n5_err_pulse_end", 32'(b5.sel_err), 32'h0);
    check("n5_old_ch_data", 32'(b5.out_data), 32'h5A);
    check("n5_old_ch", 32'(b5.out_ch), 32'h1);
    b5.in_valid = '0;
    b5.sel = 3'd4; b5.sel_load = 1'b1;
    step();
    b5.sel_load = 1'b0;
    check("n5_sel4_no_err", 32'(b5.sel_err), 32'h0);
    #1 check("n5_sel4_ready", 32'(b5.in_ready), 32'h10);

    // ---- streaming with all channels valid (round-robin when scanning) ----
    b5.sel = 3'd0; b5.sel_load = 1'b1;
    step();
    b5.sel_load = 1'b0;
    for (int c = 0; c < 5; c++) b5.in_data[c*8 +: 8] = 8'(8'h40 + c);
    b5.in_valid = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("scan_out_ch_%0d", k), 32'(b5.out_ch), SCAN ? 32'(k % 5) : 32'h0);
      check($sformatf("scan_out_data_%0d", k), 32'(b5.out_data),
            SCAN ? 32'(8'h40 + (k % 5)) : 32'h40);
    end
    b5.in_valid = '0;
    step();
    check("scan_drained", 32'(b5.out_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
